// File: rtl/rf_pkg.sv
// Shared definitions for the register-file writeback arbiter.
//   - Widths of register address, data, status and bank select.
//   - Source index constants (queue order and base of the rotating priority).
//   - Queue entry layout and the bank FSM state type.
package rf_pkg;

  localparam int unsigned ADDR_W    = 5;
  localparam int unsigned DATA_W    = 16;
  localparam int unsigned BANK_W    = 6;
  localparam int unsigned NUM_BANKS = 3;
  localparam int unsigned STATUS_W  = 2;
  localparam int unsigned NUM_SRC   = 4;

  localparam int unsigned SRC_ALU_A = 0;
  localparam int unsigned SRC_ALU_B = 1;
  localparam int unsigned SRC_LS_A  = 2;
  localparam int unsigned SRC_LS_B  = 3;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    SWITCH
  } bank_state_e;

  // Load/store sources carry a zero status field.
  typedef struct packed {
    logic [STATUS_W-1:0] status;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   data;
  } wb_entry_t;

  localparam int unsigned ENTRY_W = $bits(wb_entry_t);

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO used as a per-source writeback queue.
// Ports:
//   i_clock, i_reset_n : clock and asynchronous active-low reset
//   i_push, i_data     : enqueue (ignored when full)
//   i_pop              : dequeue head (ignored when empty)
//   o_full, o_empty    : occupancy flags
//   o_head             : oldest entry, valid while !o_empty
module wb_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_clock,
  input  logic             i_reset_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_mem [DEPTH];
  // Extra MSB distinguishes full from empty when the index bits match.
  logic [PTR_W:0]   r_wr_ptr;
  logic [PTR_W:0]   r_rd_ptr;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                   (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_head  = r_mem[r_rd_ptr[PTR_W-1:0]];

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge i_clock) begin
    if (w_push) r_mem[r_wr_ptr[PTR_W-1:0]] <= i_data;
  end

endmodule

// File: rtl/rf_writeback_arbiter.sv
// Writeback arbiter between two ALU pipes, two load/store paths and the register file.
// Each source has its own queue; up to four writes issue per cycle. When several queue
// heads target the same register, only the highest rotating-priority one issues and the
// pointer advances. Also owns the bank-select register, switching only once drained.
// Ports:
//   clock_i, reset_n_i                   : clock, asynchronous active-low reset
//   {aluA,aluB,lsA,lsB}_valid/ready      : per-source request handshake
//   {aluA,aluB,lsA,lsB}_addr/data        : destination register and data
//   aluA/aluB_status_i                   : overflow/underflow status
//   rfWe*/rfAddr*/rfData*/rfStatus*      : registered register-file write ports
//   bank_req_i, bank_sel_i               : bank change request (held until ack/err)
//   bankSelect_o, bank_ack_o, bank_err_o : current bank, completion / reject pulses
//   busy_o                               : any queue occupied or any write enable high
module rf_writeback_arbiter
  import rf_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                clock_i,
  input  logic                reset_n_i,
  input  logic                aluA_valid_i,
  input  logic                aluB_valid_i,
  output logic                aluA_ready_o,
  output logic                aluB_ready_o,
  input  logic [ADDR_W-1:0]   aluA_addr_i,
  input  logic [ADDR_W-1:0]   aluB_addr_i,
  input  logic [DATA_W-1:0]   aluA_data_i,
  input  logic [DATA_W-1:0]   aluB_data_i,
  input  logic [STATUS_W-1:0] aluA_status_i,
  input  logic [STATUS_W-1:0] aluB_status_i,
  input  logic                lsA_valid_i,
  input  logic                lsB_valid_i,
  output logic                lsA_ready_o,
  output logic                lsB_ready_o,
  input  logic [ADDR_W-1:0]   lsA_addr_i,
  input  logic [ADDR_W-1:0]   lsB_addr_i,
  input  logic [DATA_W-1:0]   lsA_data_i,
  input  logic [DATA_W-1:0]   lsB_data_i,
  output logic                rfWeA_o,
  output logic                rfWeB_o,
  output logic [ADDR_W-1:0]   rfAddrA_o,
  output logic [ADDR_W-1:0]   rfAddrB_o,
  output logic [DATA_W-1:0]   rfDataA_o,
  output logic [DATA_W-1:0]   rfDataB_o,
  output logic [STATUS_W-1:0] rfStatusA_o,
  output logic [STATUS_W-1:0] rfStatusB_o,
  output logic                rfWeLsA_o,
  output logic                rfWeLsB_o,
  output logic [ADDR_W-1:0]   rfAddrLsA_o,
  output logic [ADDR_W-1:0]   rfAddrLsB_o,
  output logic [DATA_W-1:0]   rfDataLsA_o,
  output logic [DATA_W-1:0]   rfDataLsB_o,
  input  logic                bank_req_i,
  input  logic [BANK_W-1:0]   bank_sel_i,
  output logic [BANK_W-1:0]   bankSelect_o,
  output logic                bank_ack_o,
  output logic                bank_err_o,
  output logic                busy_o
);

  localparam logic [BANK_W-1:0] BANK_LIMIT = BANK_W'(NUM_BANKS);

  logic [NUM_SRC-1:0]      w_valid;
  logic [NUM_SRC-1:0]      w_ready;
  logic [NUM_SRC-1:0]      w_push;
  logic [NUM_SRC-1:0]      w_full;
  logic [NUM_SRC-1:0]      w_empty;
  logic [NUM_SRC-1:0]      w_issue;
  wb_entry_t [NUM_SRC-1:0] w_in;
  wb_entry_t [NUM_SRC-1:0] w_head;
  logic                    w_blocked;
  logic                    w_clash;
  logic [1:0]              w_idx;
  logic [1:0]              w_jdx;

  logic [1:0]              r_ptr;
  logic [NUM_SRC-1:0]      r_we;
  wb_entry_t [NUM_SRC-1:0] r_out;
  bank_state_e             r_state;
  logic [BANK_W-1:0]       r_bank;
  logic                    r_ack;
  logic                    r_err;

  assign w_valid = {lsB_valid_i, lsA_valid_i, aluB_valid_i, aluA_valid_i};

  assign w_in[SRC_ALU_A] = '{status: aluA_status_i, addr: aluA_addr_i, data: aluA_data_i};
  assign w_in[SRC_ALU_B] = '{status: aluB_status_i, addr: aluB_addr_i, data: aluB_data_i};
  assign w_in[SRC_LS_A]  = '{status: '0, addr: lsA_addr_i, data: lsA_data_i};
  assign w_in[SRC_LS_B]  = '{status: '0, addr: lsB_addr_i, data: lsB_data_i};

  assign w_ready = ~w_full & {NUM_SRC{r_state == RUN}};
  assign w_push  = w_valid & w_ready;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_fifo
    wb_fifo #(
      .DEPTH(FIFO_DEPTH),
      .WIDTH(ENTRY_W)
    ) u_fifo (
      .i_clock  (clock_i),
      .i_reset_n(reset_n_i),
      .i_push   (w_push[g]),
      .i_data   (w_in[g]),
      .i_pop    (w_issue[g]),
      .o_full   (w_full[g]),
      .o_empty  (w_empty[g]),
      .o_head   (w_head[g])
    );
  end

  // Walk heads in rotating priority order; a head issues unless any higher-priority
  // non-empty head targets the same register.
  always_comb begin
    w_issue   = '0;
    w_blocked = 1'b0;
    w_clash   = 1'b0;
    w_idx     = '0;
    w_jdx     = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      w_idx   = r_ptr + 2'(k);
      w_clash = 1'b0;
      for (int j = 0; j < k; j++) begin
        w_jdx = r_ptr + 2'(j);
        if (!w_empty[w_jdx] && (w_head[w_jdx].addr == w_head[w_idx].addr)) w_clash = 1'b1;
      end
      if (!w_empty[w_idx]) begin
        if (w_clash) w_blocked = 1'b1;
        else         w_issue[w_idx] = 1'b1;
      end
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_ptr <= '0;
      r_we  <= '0;
      r_out <= '0;
    end else begin
      r_we <= w_issue;
      for (int i = 0; i < NUM_SRC; i++) begin
        if (w_issue[i]) r_out[i] <= w_head[i];
      end
      if (w_blocked) r_ptr <= r_ptr + 2'd1;
    end
  end

  // Bank FSM. A request seen while its own ack/err pulse is still visible is ignored so
  // a requester that drops on the pulse never triggers a second transition.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state <= RUN;
      r_bank  <= '0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      unique case (r_state)
        RUN: begin
          if (bank_req_i && !r_ack && !r_err) begin
            if (bank_sel_i >= BANK_LIMIT) r_err   <= 1'b1;
            else                          r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if ((&w_empty) && !(|r_we)) r_state <= SWITCH;
        end
        SWITCH: begin
          r_bank  <= bank_sel_i;
          r_ack   <= 1'b1;
          r_state <= RUN;
        end
        default: r_state <= RUN;
      endcase
    end
  end

  assign aluA_ready_o = w_ready[SRC_ALU_A];
  assign aluB_ready_o = w_ready[SRC_ALU_B];
  assign lsA_ready_o  = w_ready[SRC_LS_A];
  assign lsB_ready_o  = w_ready[SRC_LS_B];

  assign rfWeA_o     = r_we[SRC_ALU_A];
  assign rfWeB_o     = r_we[SRC_ALU_B];
  assign rfAddrA_o   = r_out[SRC_ALU_A].addr;
  assign rfAddrB_o   = r_out[SRC_ALU_B].addr;
  assign rfDataA_o   = r_out[SRC_ALU_A].data;
  assign rfDataB_o   = r_out[SRC_ALU_B].data;
  assign rfStatusA_o = r_out[SRC_ALU_A].status;
  assign rfStatusB_o = r_out[SRC_ALU_B].status;
  assign rfWeLsA_o   = r_we[SRC_LS_A];
  assign rfWeLsB_o   = r_we[SRC_LS_B];
  assign rfAddrLsA_o = r_out[SRC_LS_A].addr;
  assign rfAddrLsB_o = r_out[SRC_LS_B].addr;
  assign rfDataLsA_o = r_out[SRC_LS_A].data;
  assign rfDataLsB_o = r_out[SRC_LS_B].data;

  assign bankSelect_o = r_bank;
  assign bank_ack_o   = r_ack;
  assign bank_err_o   = r_err;
  assign busy_o       = ~(&w_empty) | (|r_we);

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Bench for rf_writeback_arbiter: directed scenarios plus a randomized run compared
// cycle by cycle against a queue-based reference model of the arbitration rules.
module tb_rf_writeback_arbiter;

  localparam int DEPTH = 2;

  typedef struct {
    logic [4:0]  addr;
    logic [15:0] data;
    logic [1:0]  st;
  } ent_t;

  logic        clock;
  logic        reset_n;
  logic        v   [4];
  logic [4:0]  a   [4];
  logic [15:0] d   [4];
  logic [1:0]  st  [4];
  logic        rdy [4];
  logic        we  [4];
  logic [4:0]  oa  [4];
  logic [15:0] od  [4];
  logic [1:0]  os  [2];
  logic        req;
  logic [5:0]  sel;
  logic [5:0]  bank;
  logic        ack;
  logic        err;
  logic        busy;

  int n_checks;
  int n_pass;

  // Reference model: one queue per source, rotating pointer, bank mode 0 run/1 drain/2 switch.
  ent_t       mq [4][$];
  int         mptr;
  bit         m_we [4];
  ent_t       m_out [4];
  int         m_mode;
  logic [5:0] m_bank;
  bit         m_ack;
  bit         m_err;

  rf_writeback_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
    .clock_i      (clock),
    .reset_n_i    (reset_n),
    .aluA_valid_i (v[0]),
    .aluB_valid_i (v[1]),
    .aluA_ready_o (rdy[0]),
    .aluB_ready_o (rdy[1]),
    .aluA_addr_i  (a[0]),
    .aluB_addr_i  (a[1]),
    .aluA_data_i  (d[0]),
    .aluB_data_i  (d[1]),
    .aluA_status_i(st[0]),
    .aluB_status_i(st[1]),
    .lsA_valid_i  (v[2]),
    .lsB_valid_i  (v[3]),
    .lsA_ready_o  (rdy[2]),
    .lsB_ready_o  (rdy[3]),
    .lsA_addr_i   (a[2]),
    .lsB_addr_i   (a[3]),
    .lsA_data_i   (d[2]),
    .lsB_data_i   (d[3]),
    .rfWeA_o      (we[0]),
    .rfWeB_o      (we[1]),
    .rfAddrA_o    (oa[0]),
    .rfAddrB_o    (oa[1]),
    .rfDataA_o    (od[0]),
    .rfDataB_o    (od[1]),
    .rfStatusA_o  (os[0]),
    .rfStatusB_o  (os[1]),
    .rfWeLsA_o    (we[2]),
    .rfWeLsB_o    (we[3]),
    .rfAddrLsA_o  (oa[2]),
    .rfAddrLsB_o  (oa[3]),
    .rfDataLsA_o  (od[2]),
    .rfDataLsB_o  (od[3]),
    .bank_req_i   (req),
    .bank_sel_i   (sel),
    .bankSelect_o (bank),
    .bank_ack_o   (ack),
    .bank_err_o   (err),
    .busy_o       (busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      mq[i].delete();
      m_we[i]  = 1'b0;
      m_out[i] = '{addr: '0, data: '0, st: '0};
    end
    mptr = 0; m_mode = 0; m_bank = '0; m_ack = 1'b0; m_err = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    bit         can_push [4];
    bit         iss [4];
    bit         idle;
    bit         old_ack;
    bit         old_err;
    bit         blocked;
    bit         hit;
    int         s;
    ent_t       e;
    logic [4:0] seen [$];
    idle = 1'b1;
    for (int i = 0; i < 4; i++) begin
      can_push[i] = (mq[i].size() < DEPTH) && (m_mode == 0);
      if (mq[i].size() != 0 || m_we[i]) idle = 1'b0;
      iss[i] = 1'b0;
    end
    old_ack = m_ack; old_err = m_err;
    blocked = 1'b0;
    for (int k = 0; k < 4; k++) begin
      s = (mptr + k) % 4;
      if (mq[s].size() != 0) begin
        hit = 1'b0;
        foreach (seen[q]) if (seen[q] == mq[s][0].addr) hit = 1'b1;
        if (hit) blocked = 1'b1;
        else     iss[s] = 1'b1;
        seen.push_back(mq[s][0].addr);
      end
    end
    for (int i = 0; i < 4; i++) begin
      m_we[i] = iss[i];
      if (iss[i]) m_out[i] = mq[i].pop_front();
    end
    if (blocked) mptr = (mptr + 1) % 4;
    for (int i = 0; i < 4; i++) begin
      if (v[i] && can_push[i]) begin
        e.addr = a[i]; e.data = d[i]; e.st = (i < 2) ? st[i] : 2'b00;
        mq[i].push_back(e);
      end
    end
    m_ack = 1'b0; m_err = 1'b0;
    case (m_mode)
      0: if (req && !old_ack && !old_err) begin
           if (sel >= 6'd3) m_err = 1'b1;
           else             m_mode = 1;
         end
      1: if (idle) m_mode = 2;
      default: begin m_bank = sel; m_ack = 1'b1; m_mode = 0; end
    endcase
  endtask

  task automatic tick();
    model_step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < 4; i++) begin
      v[i] = 1'b0; a[i] = '0; d[i] = '0; st[i] = '0;
    end
    req = 1'b0; sel = '0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    clear_inputs();
    model_reset();
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (we[i] !== 1'b0) $display("FAIL reset_we%0d: got %b want 0", i, we[i]); else n_pass++;
      n_checks++; if (rdy[i] !== 1'b1) $display("FAIL reset_ready%0d: got %b want 1", i, rdy[i]); else n_pass++;
      n_checks++; if (od[i] !== 16'h0) $display("FAIL reset_data%0d: got %h want 0", i, od[i]); else n_pass++;
    end
    n_checks++; if (bank !== 6'd0) $display("FAIL reset_bank: got %0d want 0", bank); else n_pass++;
    n_checks++; if ({ack, err, busy} !== 3'b000) $display("FAIL reset_ack_err_busy: got %b want 000", {ack, err, busy}); else n_pass++;
  endtask

  task automatic test_single_alu();
    do_reset();
    v[0] = 1'b1; a[0] = 5'd5; d[0] = 16'h1234; st[0] = 2'b10;
    tick();
    v[0] = 1'b0;
    n_checks++; if (we[0] !== 1'b0) $display("FAIL single_early: got %b want 0", we[0]); else n_pass++;
    tick();
    n_checks++; if (we[0] !== 1'b1) $display("FAIL single_we: got %b want 1", we[0]); else n_pass++;
    n_checks++; if ({oa[0], od[0], os[0]} !== {5'd5, 16'h1234, 2'b10})
      $display("FAIL single_fields: got %0d/%h/%b want 5/1234/10", oa[0], od[0], os[0]); else n_pass++;
    tick();
    n_checks++; if (we[0] !== 1'b0) $display("FAIL single_one_cycle: got %b want 0", we[0]); else n_pass++;
  endtask

  task automatic test_collision();
    do_reset();
    v[0] = 1'b1; a[0] = 5'd7; d[0] = 16'hAAAA;
    v[3] = 1'b1; a[3] = 5'd7; d[3] = 16'hBBBB;
    tick();
    v[0] = 1'b0; v[3] = 1'b0;
    tick();
    n_checks++; if ({we[0], we[3]} !== 2'b10) $display("FAIL coll_first: got weA,weLsB=%b%b want 10", we[0], we[3]); else n_pass++;
    n_checks++; if (od[0] !== 16'hAAAA) $display("FAIL coll_first_data: got %h want aaaa", od[0]); else n_pass++;
    tick();
    n_checks++; if ({we[0], we[3]} !== 2'b01) $display("FAIL coll_second: got weA,weLsB=%b%b want 01", we[0], we[3]); else n_pass++;
    n_checks++; if ({oa[3], od[3]} !== {5'd7, 16'hBBBB}) $display("FAIL coll_second_data: got %0d/%h want 7/bbbb", oa[3], od[3]); else n_pass++;
    // Pointer should now be 1, so aluB wins a tie against aluA.
    v[0] = 1'b1; a[0] = 5'd9; d[0] = 16'h0001;
    v[1] = 1'b1; a[1] = 5'd9; d[1] = 16'h0002;
    tick();
    v[0] = 1'b0; v[1] = 1'b0;
    tick();
    n_checks++; if ({we[0], we[1]} !== 2'b01) $display("FAIL coll_ptr1: got weA,weB=%b%b want 01", we[0], we[1]); else n_pass++;
    tick();
    n_checks++; if ({we[0], we[1]} !== 2'b10) $display("FAIL coll_ptr1_next: got weA,weB=%b%b want 10", we[0], we[1]); else n_pass++;
  endtask

  task automatic test_all_four();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      v[i] = 1'b1; a[i] = 5'(i + 1); d[i] = 16'(16'h4000 + i);
    end
    tick();
    for (int i = 0; i < 4; i++) v[i] = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (we[i] !== 1'b1 || oa[i] !== 5'(i + 1))
        $display("FAIL all4_src%0d: got we=%b addr=%0d want 1/%0d", i, we[i], oa[i], i + 1); else n_pass++;
    end
    // No collision, so pointer stays 0 and aluA wins a tie.
    v[0] = 1'b1; a[0] = 5'd9; d[0] = 16'h0011;
    v[1] = 1'b1; a[1] = 5'd9; d[1] = 16'h0022;
    tick();
    v[0] = 1'b0; v[1] = 1'b0;
    tick();
    n_checks++; if ({we[0], we[1]} !== 2'b10) $display("FAIL all4_ptr0: got weA,weB=%b%b want 10", we[0], we[1]); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [15:0] got [$];
    bit          acc;
    int          sent;
    do_reset();
    sent = 0;
    for (int c = 0; c < 16; c++) begin
      if (we[2]) got.push_back(od[2]);
      v[0] = (c < 2); a[0] = 5'd10; d[0] = 16'(16'h0100 + c);
      if (sent < 3) begin v[2] = 1'b1; a[2] = 5'd10; d[2] = 16'(16'h0A00 + sent); end
      else v[2] = 1'b0;
      if (c == 2) begin
        n_checks++; if (rdy[2] !== 1'b0) $display("FAIL bp_ready_low: got %b want 0", rdy[2]); else n_pass++;
      end
      acc = v[2] && rdy[2];
      tick();
      if (acc) sent++;
    end
    v[0] = 1'b0; v[2] = 1'b0;
    n_checks++; if (sent !== 3) $display("FAIL bp_accepted: got %0d want 3", sent); else n_pass++;
    n_checks++; if (got.size() !== 3) $display("FAIL bp_count: got %0d want 3", got.size()); else n_pass++;
    foreach (got[i]) begin
      n_checks++; if (got[i] !== 16'(16'h0A00 + i)) $display("FAIL bp_order%0d: got %h want %h", i, got[i], 16'h0A00 + i); else n_pass++;
    end
  endtask

  task automatic test_bank_switch();
    int writes;
    int acks;
    do_reset();
    v[0] = 1'b1; a[0] = 5'd3; d[0] = 16'h0011;
    v[1] = 1'b1; a[1] = 5'd3; d[1] = 16'h0022;
    req = 1'b1; sel = 6'd2;
    tick();
    v[0] = 1'b0; v[1] = 1'b0;
    n_checks++; if ({rdy[0], rdy[1], rdy[2], rdy[3]} !== 4'b0000)
      $display("FAIL bank_ready_low: got %b%b%b%b want 0000", rdy[0], rdy[1], rdy[2], rdy[3]); else n_pass++;
    writes = 0; acks = 0;
    for (int c = 0; c < 20; c++) begin
      if (we[0] || we[1] || we[2] || we[3]) begin
        writes++;
        n_checks++; if (bank !== 6'd0) $display("FAIL bank_write_old: got bank %0d want 0", bank); else n_pass++;
      end
      if (ack) begin
        acks++;
        n_checks++; if (bank !== 6'd2) $display("FAIL bank_at_ack: got %0d want 2", bank); else n_pass++;
        req = 1'b0;
      end
      tick();
    end
    req = 1'b0;
    n_checks++; if (writes !== 2) $display("FAIL bank_drained: got %0d writes want 2", writes); else n_pass++;
    n_checks++; if (acks !== 1) $display("FAIL bank_ack_count: got %0d want 1", acks); else n_pass++;
    n_checks++; if (bank !== 6'd2) $display("FAIL bank_final: got %0d want 2", bank); else n_pass++;
  endtask

  task automatic test_bank_err();
    req = 1'b1; sel = 6'd3;
    tick();
    n_checks++; if (err !== 1'b1) $display("FAIL err_pulse: got %b want 1", err); else n_pass++;
    n_checks++; if (bank !== 6'd2) $display("FAIL err_bank_kept: got %0d want 2", bank); else n_pass++;
    req = 1'b0;
    tick();
    n_checks++; if (err !== 1'b0) $display("FAIL err_one_cycle: got %b want 0", err); else n_pass++;
    n_checks++; if (rdy[0] !== 1'b1) $display("FAIL err_stays_run: got ready %b want 1", rdy[0]); else n_pass++;
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    v[0] = 1'b1; a[0] = 5'd5; d[0] = 16'h0055;
    v[3] = 1'b1; a[3] = 5'd5; d[3] = 16'h0066;
    req = 1'b1; sel = 6'd1;
    tick();
    v[0] = 1'b0; v[3] = 1'b0;
    tick();
    n_checks++; if (we[0] !== 1'b1) $display("FAIL rst_drain_pre: got weA %b want 1", we[0]); else n_pass++;
    reset_n = 1'b0;
    #1;
    n_checks++; if ({we[0], we[1], we[2], we[3]} !== 4'b0000)
      $display("FAIL rst_drain_we: got %b%b%b%b want 0000", we[0], we[1], we[2], we[3]); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_drain_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (rdy[3] !== 1'b1) $display("FAIL rst_drain_ready: got %b want 1", rdy[3]); else n_pass++;
    n_checks++; if (bank !== 6'd0) $display("FAIL rst_drain_bank: got %0d want 0", bank); else n_pass++;
    req = 1'b0;
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_random();
    bit exp_busy;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      exp_busy = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (mq[i].size() != 0 || m_we[i]) exp_busy = 1'b1;
        n_checks++; if (rdy[i] !== ((mq[i].size() < DEPTH) && (m_mode == 0)))
          $display("FAIL rnd_ready%0d cyc %0d: got %b", i, cyc, rdy[i]); else n_pass++;
        n_checks++; if (we[i] !== m_we[i])
          $display("FAIL rnd_we%0d cyc %0d: got %b want %b", i, cyc, we[i], m_we[i]); else n_pass++;
        if (m_we[i]) begin
          n_checks++; if ({oa[i], od[i]} !== {m_out[i].addr, m_out[i].data})
            $display("FAIL rnd_wr%0d cyc %0d: got %0d/%h want %0d/%h", i, cyc, oa[i], od[i],
                     m_out[i].addr, m_out[i].data); else n_pass++;
          if (i < 2) begin
            n_checks++; if (os[i] !== m_out[i].st)
              $display("FAIL rnd_status%0d cyc %0d: got %b want %b", i, cyc, os[i], m_out[i].st); else n_pass++;
          end
        end
      end
      n_checks++; if ({bank, ack, err} !== {m_bank, m_ack, m_err})
        $display("FAIL rnd_bank cyc %0d: got %0d/%b/%b want %0d/%b/%b", cyc, bank, ack, err,
                 m_bank, m_ack, m_err); else n_pass++;
      n_checks++; if (busy !== exp_busy) $display("FAIL rnd_busy cyc %0d: got %b want %b", cyc, busy, exp_busy); else n_pass++;
      for (int i = 0; i < 4; i++) begin
        v[i] = 1'($urandom_range(0, 1));
        a[i] = 5'($urandom_range(0, 3));
        d[i] = 16'($urandom);
        st[i] = 2'($urandom_range(0, 3));
      end
      if (req && (m_ack || m_err)) req = 1'b0;
      else if (!req && $urandom_range(0, 29) == 0) begin
        req = 1'b1;
        sel = 6'($urandom_range(0, 4));
      end
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset_n  = 1'b0;
    clear_inputs();
    test_reset();
    test_single_alu();
    test_collision();
    test_all_four();
    test_backpressure();
    test_bank_switch();
    test_bank_err();
    test_reset_mid_drain();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rf_writeback_arbiter.md
Name: rf_writeback_arbiter

Overview:
Sits between the two arithmetic pipes, the two load/store writeback paths and the register file write ports. Each source gets a small queue. The block issues up to four register writes per cycle and resolves same-address collisions with rotating priority, so the register file never sees two enables to one index in a cycle. It also owns the bank-select register and changes bank only after all pending writebacks have drained.

Parameters:
FIFO_DEPTH, 2, entries per source queue (power of two, >=2)
ADDR_W, 5, register address width within a bank
DATA_W, 16, register data width
BANK_W, 6, bank-select width
NUM_BANKS, 3, number of implemented banks; requests at or above this are rejected

Ports:
clock_i  in  1  clock, all state on rising edge
reset_n_i  in  1  asynchronous active-low reset
aluA_valid_i, aluB_valid_i  in  1 each  arithmetic writeback request
aluA_ready_o, aluB_ready_o  out  1 each  request accepted when valid&ready at edge
aluA_addr_i, aluB_addr_i  in  ADDR_W each  destination register
aluA_data_i, aluB_data_i  in  DATA_W each  write data
aluA_status_i, aluB_status_i  in  2 each  overflow/underflow status
lsA_valid_i, lsB_valid_i  in  1 each  load/store writeback request
lsA_ready_o, lsB_ready_o  out  1 each  handshake ready
lsA_addr_i, lsB_addr_i  in  ADDR_W each  destination register
lsA_data_i, lsB_data_i  in  DATA_W each  write data
rfWeA_o, rfWeB_o  out  1 each  register file arithmetic write enables
rfAddrA_o, rfAddrB_o  out  ADDR_W each  arithmetic write addresses
rfDataA_o, rfDataB_o  out  DATA_W each  arithmetic write data
rfStatusA_o, rfStatusB_o  out  2 each  status to register file
rfWeLsA_o, rfWeLsB_o  out  1 each  load/store write enables
rfAddrLsA_o, rfAddrLsB_o  out  ADDR_W each  load/store write addresses
rfDataLsA_o, rfDataLsB_o  out  DATA_W each  load/store write data
bank_req_i  in  1  bank change request, held until ack or err
bank_sel_i  in  BANK_W  requested bank
bankSelect_o  out  BANK_W  current bank to register file
bank_ack_o  out  1  one-cycle pulse: bank changed
bank_err_o  out  1  one-cycle pulse: bank_sel_i >= NUM_BANKS, bank unchanged
busy_o  out  1  any queue non-empty or any rf enable asserted

Behaviour:
- Reset (async assert, sync release): queues empty, all enables 0, addr/data/status outputs 0, bankSelect_o 0, ack/err 0, rotation pointer 0, state RUN.
- Source index order: 0 aluA, 1 aluB, 2 lsA, 3 lsB. Each has its own FIFO_DEPTH FIFO.
- ready_o = queue not full AND state==RUN. No bypass when full.
- Priority order each cycle: ptr, ptr+1, ptr+2, ptr+3 (mod 4).
- A valid head issues iff no higher-priority valid head has the same address. All non-colliding heads issue in the same cycle. An issued entry is popped.
- If any head was blocked this cycle, ptr <= ptr+1. Otherwise ptr holds.
- Issue drives registered outputs: the source's rf port gets enable=1 plus addr/data (and status for alu sources) for exactly one cycle.
- Latency: an entry accepted at edge k, if not blocked, shows its enable from edge k+1 to edge k+2. The register file writes it at edge k+2.
- Per-source order is preserved (FIFO). Nothing is ordered across sources except by collision priority.
- Bank FSM:
  - RUN: when bank_req_i is high and bank_sel_i >= NUM_BANKS, pulse bank_err_o and stay in RUN. The requester must drop bank_req_i.
  - RUN: when bank_req_i is high with a legal bank, go to DRAIN. All ready_o go low from the next cycle.
  - DRAIN: when all queues are empty and all rf enables are 0, go to SWITCH.
  - SWITCH: bankSelect_o <= bank_sel_i, bank_ack_o pulses, go to RUN.
  - Minimum RUN->RUN is 3 cycles even when the block is idle.
- An entry accepted in the same edge as the RUN->DRAIN transition is drained into the old bank.
- Reset mid-DRAIN discards queued writes and sets bank 0.

Decomposition:
- Shared package rf_pkg: ADDR_W, DATA_W, BANK_W, NUM_BANKS, source index constants, FSM state enum {RUN, DRAIN, SWITCH}.
- One sub-module: wb_fifo (depth-parameterised, push/pop/full/empty/head). Instantiated four times.

Test Plan:
- Single aluA write addr 5 data 16'h1234 status 2'b10 -> rfWeA_o high for exactly one cycle, one edge after acceptance, with rfAddrA_o=5, rfDataA_o=16'h1234, rfStatusA_o=2'b10.
- aluA and lsB both target addr 7 in the same cycle, ptr=0 -> aluA issues first and lsB issues the next cycle. ptr becomes 1. Never are two enables with addr 7 asserted together.
- All four sources with distinct addresses 1,2,3,4 -> all four enables asserted in the same cycle. ptr unchanged.
- Push 3 back-to-back writes to lsA while it is blocked by collisions -> lsA_ready_o goes low after 2 entries. Writes issue in order, with none lost or duplicated.
- With 2 queued writes, bank_req_i with bank_sel_i=2 -> ready_o goes low, both writes issue on bank 0, then bankSelect_o=2 and bank_ack_o pulses once.
- bank_sel_i=3 -> bank_err_o pulses, bankSelect_o unchanged. Asserting reset_n_i low mid-DRAIN clears all enables and queues immediately, without waiting for a clock edge.
